kick_sample_recorder: RTL and testbench

Capture block that writes a drum sample into the kick sample RAM. It is the writer-side counterpart of the kick playback counter, which reads the RAM at addresses 0..MAXCOUNT-1. On a record request the block arms and waits for an audio sample whose magnitude meets a threshold. It then streams consecutive valid samples into the RAM from address 0 and reports the captured length, which playback uses as its end address.

---
 rtl/kick_sample_recorder.sv | 128 ++++++++++++
 tb/tb_kick_sample_recorder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/kick_sample_recorder.sv
// Kick sample recorder: arms on request, waits for a sample above threshold,
// then streams consecutive valid samples into the sample RAM from address 0.
module kick_sample_recorder #(
    parameter int unsigned MAXCOUNT  = 43840,
    parameter logic [15:0] THRESHOLD = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rec,
    input  logic        stop,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [15:0] length,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LastAddr = 16'(MAXCOUNT - 1);

    typedef enum logic [1:0] {StIdle, StArm, StRecord, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] length_q, length_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // 17-bit magnitude so that -32768 maps to 32768 without overflow
    logic [16:0] magnitude;
    logic        qualifies;

    always_comb begin
        if (sample_in[15]) begin
            magnitude = ~{1'b1, sample_in} + 17'd1;
        end else begin
            magnitude = {1'b0, sample_in};
        end
        qualifies = (magnitude >= {1'b0, THRESHOLD});
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        length_d  = length_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (rec) begin
                    addr_d  = 16'd0;
                    state_d = StArm;
                end
            end
            StArm: begin
                // stop takes priority over a qualifying sample
                if (stop) begin
                    state_d = StDone;
                end else if (sample_valid && qualifies) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = 16'd0;
                    wr_data_d = sample_in;
                    addr_d    = 16'd1;
                    state_d   = StRecord;
                end
            end
            StRecord: begin
                if (sample_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = sample_in;
                    addr_d    = addr_q + 16'd1;
                    if (addr_q == LastAddr || stop) begin
                        state_d = StDone;
                    end
                end else if (stop) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                length_d = addr_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StArm) || (state_d == StRecord);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= 16'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 16'd0;
            wr_data_q <= 16'd0;
            length_q  <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            length_q  <= length_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign length  = length_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_kick_sample_recorder.sv
// Scoreboard bench for kick_sample_recorder: stimulus pushes expected writes and
// take lengths; a negedge monitor pops and compares whenever the DUT presents them.
module tb_kick_sample_recorder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec = 1'b0;
    logic        stop = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = 16'd0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] length;
    logic        busy;
    logic        done;

    kick_sample_recorder #(
        .MAXCOUNT (8),
        .THRESHOLD(16'd1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rec         (rec),
        .stop        (stop),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .length      (length),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_len[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample away from the active edge
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write_addr", {16'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr_addr", {16'd0, wr_addr}, {16'd0, e.a});
                chk("wr_data", {16'd0, wr_data}, {16'd0, e.d});
            end
        end
        if (done === 1'b1) begin
            if (exp_len.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [15:0] l;
                l = exp_len.pop_front();
                chk("length_at_done", {16'd0, length}, {16'd0, l});
            end
        end
    end

    task automatic cyc(input logic v, input logic [15:0] d, input logic s, input logic r);
        sample_valid = v;
        sample_in    = d;
        stop         = s;
        rec          = r;
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
        stop         = 1'b0;
        rec          = 1'b0;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic drained(input string name);
        chk({name, "_writes_pending"}, exp_wr.size(), 32'd0);
        chk({name, "_dones_pending"}, exp_len.size(), 32'd0);
        chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
        chk("rst_length", {16'd0, length}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        idle(1);

        // Basic take: 100 and -500 below threshold, 1024 starts capture
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        chk("t1_busy_after_rec", {31'd0, busy}, 32'd1);
        cyc(1'b1, 16'd100, 1'b0, 1'b0);
        cyc(1'b1, 16'hFE0C, 1'b0, 1'b0);
        push_wr(16'd0, 16'd1024);
        cyc(1'b1, 16'd1024, 1'b0, 1'b0);
        push_wr(16'd1, 16'd7);
        cyc(1'b1, 16'd7, 1'b0, 1'b0);
        push_wr(16'd2, 16'd9);
        cyc(1'b1, 16'd9, 1'b0, 1'b0);
        exp_len.push_back(16'd3);
        cyc(1'b0, 16'd0, 1'b1, 1'b0);
        chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        idle(4);
        drained("t1");
        chk("t1_length_held", {16'd0, length}, 32'd3);

        // Fill: back-to-back samples run to the last address, no wrap
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i < 8) push_wr(16'(i), 16'h2000 + 16'(i));
            if (i == 7) exp_len.push_back(16'd8);
            cyc(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
        end
        idle(4);
        drained("fill");
        chk("fill_length_held", {16'd0, length}, 32'd8);

        // Stop in ARM with only sub-threshold samples (1023 and -1023)
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        cyc(1'b1, 16'd1023, 1'b0, 1'b0);
        cyc(1'b1, 16'hFC01, 1'b0, 1'b0);
        chk("arm_busy", {31'd0, busy}, 32'd1);
        exp_len.push_back(16'd0);
        cyc(1'b0, 16'd0, 1'b1, 1'b0);
        chk("arm_busy_falls", {31'd0, busy}, 32'd0);
        idle(4);
        drained("armstop");

        // RECORD: -1024 starts, rec ignored mid-take, stop with -32768 still writes it
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        push_wr(16'd0, 16'hFC00);
        cyc(1'b1, 16'hFC00, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        chk("rec_ignored_busy", {31'd0, busy}, 32'd1);
        push_wr(16'd1, 16'd5);
        cyc(1'b1, 16'd5, 1'b0, 1'b0);
        push_wr(16'd2, 16'h8000);
        exp_len.push_back(16'd3);
        cyc(1'b1, 16'h8000, 1'b1, 1'b0);
        idle(4);
        drained("recstop");

        // ARM: stop together with qualifying -32768 wins, nothing written
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        exp_len.push_back(16'd0);
        cyc(1'b1, 16'h8000, 1'b1, 1'b0);
        idle(4);
        drained("armsim");

        // Asynchronous reset mid-RECORD, then a fresh take from address 0
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        push_wr(16'd0, 16'd1234);
        cyc(1'b1, 16'd1234, 1'b0, 1'b0);
        push_wr(16'd1, 16'd2000);
        cyc(1'b1, 16'd2000, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst_wr_addr", {16'd0, wr_addr}, 32'd0);
        chk("arst_wr_data", {16'd0, wr_data}, 32'd0);
        chk("arst_length", {16'd0, length}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(2);
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        push_wr(16'd0, 16'd1500);
        cyc(1'b1, 16'd1500, 1'b0, 1'b0);
        push_wr(16'd1, 16'd3);
        cyc(1'b1, 16'd3, 1'b0, 1'b0);
        exp_len.push_back(16'd2);
        cyc(1'b0, 16'd0, 1'b1, 1'b0);
        idle(4);
        drained("after_rst");
        chk("after_rst_length", {16'd0, length}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
